restoring_divider: RTL and testbench
====================================

# restoring_divider

- Sequential shift-subtract (restoring) divider.
- Performs the inverse operation of the team's shift-add multiplier and reuses its START/READY handshake and combined AQ result register.
- Takes a 2N-bit dividend and an N-bit divisor; returns remainder in AQ[2N-1:N] and quotient in AQ[N-1:0].
- Sits beside the multiplier in the arithmetic datapath and is driven by the same sequencer.

## Interface
- N, default 8: operand width; dividend and AQ are 2N bits, divisor and quotient are N bits.
- clock  in  1  rising-edge system clock; the block has one clock.
- n_reset  in  1  asynchronous, active-low reset.
- START  in  1  request; an operation begins on a START rising edge while idle.
- DIVIDEND  in  2N  dividend; sampled on the accepting edge only.
- DIVISOR  in  N  divisor; sampled on the accepting edge only.
- READY  out  1  high when idle and AQ holds a valid result.
- AQ  out  2N  {remainder, quotient} on normal completion.
- DIV_ZERO  out  1  last accepted request had DIVISOR == 0.
- OVERFLOW  out  1  last accepted request had a quotient that does not fit in N bits.

## Operation
- States: IDLE, RUN. Registers:
  - A: N+1 bits; the extra MSB is the shift-out bit.
  - Q: N bits.
  - M: N bits.
  - Iteration counter: clog2(N+1) bits.
  - start_q: START delayed one cycle.
- Acceptance: in IDLE when START=1 and start_q=0.
  - START held high does not retrigger.
  - A START rising edge seen during RUN is ignored and not queued.
- On the accepting edge:
  - DIV_ZERO and OVERFLOW are cleared first, then re-evaluated.
  - DIVISOR == 0: DIV_ZERO=1, OVERFLOW=0, AQ=DIVIDEND, stay IDLE, READY stays 1.
  - Otherwise, if DIVIDEND[2N-1:N] >= DIVISOR: OVERFLOW=1, AQ=DIVIDEND, stay IDLE, READY stays 1.
  - Otherwise: A={1'b0, DIVIDEND[2N-1:N]}, Q=DIVIDEND[N-1:0], M=DIVISOR, counter=0, READY=0, state=RUN.
- Each RUN edge performs one iteration:
  - {A,Q} shifted left by 1; the new Q[0] is provisionally 0.
  - D = shifted A − {1'b0,M}, computed at N+1 bits.
  - If D ≥ 0 (no borrow): A=D and Q[0]=1.
  - Otherwise A keeps its shifted value (restore).
  - Counter increments.
- On the edge where the counter reaches N:
  - Transition to IDLE and set READY=1.
  - AQ shows {A[N-1:0], Q}. A[N] is always 0 at this point because the remainder is below M.
- AQ is driven directly from {A[N-1:0], Q} at all times, so AQ shows intermediate values during RUN. Consumers sample AQ only while READY=1.
- The overflow pre-check guarantees the quotient fits in N bits and the remainder is less than the divisor.

## Timing
- Reset (n_reset=0, asynchronous, effective immediately):
  - State=IDLE, READY=1, AQ=0, DIV_ZERO=0, OVERFLOW=0, A/Q/M/counter=0, start_q=0.
- Reset asserted mid-RUN aborts the operation with the values above. The first START rising edge after reset release is accepted normally.
- Normal latency:
  - Accepting edge E0; READY falls after E0.
  - Iterations run on E1..EN; READY rises after EN.
  - READY is low for exactly N cycles.
  - For N=8: 8 cycles low, result valid from E8 onward.
- Fault latency: zero. READY never drops, and the flag is valid after E0.
- The result and flags hold until the next accepted START or reset.
- The earliest back-to-back acceptance is E(N+1), and only if START fell and rose again.

## Test plan
- Reset check: assert n_reset=0 asynchronously between clock edges -> READY=1, AQ=0x0000, DIV_ZERO=0, OVERFLOW=0 immediately.
- Normal divide: DIVIDEND=0x03E8, DIVISOR=0x07, START pulse -> READY low for 8 cycles, then AQ=0x068E (R=6, Q=142), flags 0.
- Extra-bit boundary: DIVIDEND=0xFEFF, DIVISOR=0xFF -> AQ=0xFEFF (R=254, Q=255). This exercises the 9-bit subtraction.
- Divide by zero: DIVIDEND=0x1234, DIVISOR=0x00 -> DIV_ZERO=1, READY never drops, AQ=0x1234. A following valid request clears DIV_ZERO.
- Overflow: DIVIDEND=0x0800, DIVISOR=0x08 -> OVERFLOW=1, AQ=0x0800, READY stays 1. Then DIVIDEND=0x0064, DIVISOR=0x0A -> OVERFLOW=0, AQ=0x000A.
- Handshake edge cases, each a separate check:
  - START held high for 20 cycles -> exactly one operation.
  - A new START rising edge at E3 of RUN -> ignored; result unchanged.
  - n_reset pulsed at E4 of RUN -> AQ=0, READY=1; the next START then completes correctly.

Source files
------------

// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential shift-subtract (restoring) divider. One iteration per clock,
//   N iterations per operation. Shares the START/READY handshake and the
//   combined {remainder, quotient} AQ register layout of the shift-add
//   multiplier, so the same sequencer can drive either block.
//
// Ports
//   clock     rising-edge system clock
//   n_reset   asynchronous active-low reset
//   START     request; accepted on a rising edge while idle
//   DIVIDEND  2N-bit dividend, sampled on the accepting edge
//   DIVISOR   N-bit divisor, sampled on the accepting edge
//   READY     idle and AQ holds a valid result
//   AQ        {remainder, quotient}; shows working values while busy
//   DIV_ZERO  last accepted request had DIVISOR == 0
//   OVERFLOW  last accepted request had a quotient wider than N bits
module restoring_divider #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           START,
  input  logic [2*N-1:0] DIVIDEND,
  input  logic [N-1:0]   DIVISOR,
  output logic           READY,
  output logic [2*N-1:0] AQ,
  output logic           DIV_ZERO,
  output logic           OVERFLOW
);

  localparam int CW = $clog2(N+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [N:0]     a;        // partial remainder; MSB catches the shift-out bit
  logic [N-1:0]   q;
  logic [N-1:0]   m;
  logic [CW-1:0]  cnt;
  logic           start_q;

  // Shift {A,Q} left one place. Keeping the whole of A in the shifted
  // value gives an N+2-bit minuend whose top bit is zero whenever A < M,
  // so the subtraction's MSB is a clean borrow flag.
  logic [N+1:0]   sh_a;
  logic [N-1:0]   sh_q;
  logic [N+1:0]   diff;
  logic           borrow;

  assign sh_a   = {a, q[N-1]};
  assign sh_q   = q << 1;
  assign diff   = sh_a - {2'b00, m};
  assign borrow = diff[N+1];

  assign AQ = {a[N-1:0], q};

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      READY    <= 1'b1;
      DIV_ZERO <= 1'b0;
      OVERFLOW <= 1'b0;
      a        <= '0;
      q        <= '0;
      m        <= '0;
      cnt      <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= START;
      case (state)
        IDLE: begin
          if (START && !start_q) begin
            // Faults report immediately with the dividend echoed on AQ.
            a <= {1'b0, DIVIDEND[2*N-1:N]};
            q <= DIVIDEND[N-1:0];
            if (DIVISOR == '0) begin
              DIV_ZERO <= 1'b1;
              OVERFLOW <= 1'b0;
            end else if (DIVIDEND[2*N-1:N] >= DIVISOR) begin
              // Upper half >= divisor means the quotient needs > N bits.
              DIV_ZERO <= 1'b0;
              OVERFLOW <= 1'b1;
            end else begin
              DIV_ZERO <= 1'b0;
              OVERFLOW <= 1'b0;
              m        <= DIVISOR;
              cnt      <= '0;
              READY    <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (borrow) begin
            a <= sh_a[N:0];                 // restore: keep shifted value
            q <= sh_q;
          end else begin
            a <= diff[N:0];
            q <= sh_q | {{(N-1){1'b0}}, 1'b1};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N-1)) begin
            READY <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
  localparam int N = 8;

  logic          clock = 1'b0;
  logic          n_reset = 1'b0;
  logic          START = 1'b0;
  logic [15:0]   DIVIDEND = '0;
  logic [7:0]    DIVISOR = '0;
  logic          READY;
  logic [15:0]   AQ;
  logic          DIV_ZERO;
  logic          OVERFLOW;

  restoring_divider #(.N(N)) dut (
    .clock(clock), .n_reset(n_reset), .START(START),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .READY(READY), .AQ(AQ), .DIV_ZERO(DIV_ZERO), .OVERFLOW(OVERFLOW)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  // scoreboard entry: {AQ, DIV_ZERO, OVERFLOW}
  logic [17:0] sb[$];
  int          lat_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model from plain integer division.
  task automatic push_exp(input logic [15:0] dd, input logic [7:0] dv);
    int unsigned qq, rr;
    if (dv == 0) begin
      sb.push_back({dd, 1'b1, 1'b0}); lat_q.push_back(0);
    end else if (dd[15:8] >= dv) begin
      sb.push_back({dd, 1'b0, 1'b1}); lat_q.push_back(0);
    end else begin
      qq = 32'(dd) / 32'(dv);
      rr = 32'(dd) % 32'(dv);
      sb.push_back({rr[7:0], qq[7:0], 1'b0, 1'b0}); lat_q.push_back(N);
    end
  endtask

  // Ends at the negedge after the accepting edge E0.
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clock);
    DIVIDEND = dd; DIVISOR = dv; START = 1'b1;
    @(negedge clock);
    START = 1'b0;
  endtask

  task automatic wait_check(input string tag, input int low_left);
    int lc = 0;
    logic [17:0] e;
    int el;
    while (!READY && lc < 60) begin
      @(negedge clock);
      lc++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e  = sb.pop_front();
      el = lat_q.pop_front();
      chk({tag, "_lat"}, 32'(lc), 32'(low_left < 0 ? el : low_left));
      chk({tag, "_aq"}, 32'(AQ), 32'(e[17:2]));
      chk({tag, "_dz"}, 32'(DIV_ZERO), 32'(e[1]));
      chk({tag, "_ov"}, 32'(OVERFLOW), 32'(e[0]));
    end
    @(negedge clock);
  endtask

  task automatic do_op(input string tag, input logic [15:0] dd, input logic [7:0] dv);
    push_exp(dd, dv);
    start_op(dd, dv);
    wait_check(tag, -1);
  endtask

  initial begin
    int ops;
    logic prev;
    logic [15:0] rd;
    logic [7:0]  rv;

    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_aq", 32'(AQ), 32'h0);

    // Overflow, then a valid request clears it.
    do_op("ovf", 16'h0800, 8'h08);
    chk("ovf_const", 32'(AQ), 32'h0800);

    // Asynchronous reset between edges takes effect immediately.
    #2 n_reset = 1'b0;
    #1;
    chk("arst_ready", 32'(READY), 32'd1);
    chk("arst_aq", 32'(AQ), 32'h0);
    chk("arst_dz", 32'(DIV_ZERO), 32'd0);
    chk("arst_ov", 32'(OVERFLOW), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;

    do_op("ovf2", 16'h0800, 8'h08);
    do_op("after_ovf", 16'h0064, 8'h0A);
    chk("after_ovf_const", 32'(AQ), 32'h000A);

    do_op("normal", 16'h03E8, 8'h07);
    chk("normal_const", 32'(AQ), 32'h068E);

    do_op("extrabit", 16'hFEFF, 8'hFF);
    chk("extrabit_const", 32'(AQ), 32'hFEFF);

    do_op("divzero", 16'h1234, 8'h00);
    do_op("after_dz", 16'h00FF, 8'h10);

    // START held high: exactly one operation.
    push_exp(16'h2710, 8'h64);
    @(negedge clock);
    DIVIDEND = 16'h2710; DIVISOR = 8'h64; START = 1'b1;
    ops = 0; prev = READY;
    repeat (20) begin
      @(negedge clock);
      if (prev && !READY) ops++;
      prev = READY;
    end
    START = 1'b0;
    chk("held_ops", 32'(ops), 32'd1);
    wait_check("held", 0);

    // Rising START during RUN at E3 is ignored.
    push_exp(16'h03E8, 8'h07);
    start_op(16'h03E8, 8'h07);
    @(negedge clock);
    @(negedge clock);
    DIVIDEND = 16'h0001; DIVISOR = 8'h03; START = 1'b1;
    @(negedge clock);
    START = 1'b0;
    wait_check("midstart", N - 3);

    // Reset pulsed at E4 of RUN aborts; next request completes.
    start_op(16'h1234, 8'h56);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 n_reset = 1'b0;
    #1;
    chk("abort_ready", 32'(READY), 32'd1);
    chk("abort_aq", 32'(AQ), 32'h0);
    @(negedge clock);
    n_reset = 1'b1;
    do_op("post_abort", 16'h1234, 8'h56);

    // Random in-range and fault requests.
    for (int i = 0; i < 10; i++) begin
      rv = 8'($urandom_range(0, 255));
      rd = 16'($urandom);
      if (i % 3 != 0 && rv != 0) rd[15:8] = 8'(rd[15:8] % rv);
      do_op("rand", rd, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
